onchip_mem_tester: RTL
======================

ONCHIP_MEM_TESTER -- requirements
Module: onchip_mem_tester

Interface
REQ-001 Parameter ADDR_W, default 13, word-address width of the target memory.
REQ-002 Parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 Parameter RD_LAT, default 1, fixed read latency of the target in clocks (1..2).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin a test run.
REQ-007 base_addr  input  ADDR_W  first word address tested.
REQ-008 word_count  input  ADDR_W+1  number of words tested, 0..2^ADDR_W.
REQ-009 seed  input  DATA_W  pattern seed.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high from run completion until the next accepted start.
REQ-012 pass  output  1  valid while done; 1 means zero mismatches.
REQ-013 err_count  output  ADDR_W+1  mismatches in the last run.
REQ-014 first_err_addr  output  ADDR_W  address of the first mismatch; 0 if none.
REQ-015 avm_address  output  ADDR_W  Avalon-MM master word address.
REQ-016 avm_chipselect, avm_write  output  1 each  transfer qualifiers.
REQ-017 avm_byteenable  output  DATA_W/8  always all-ones.
REQ-018 avm_writedata  output  DATA_W  write data.
REQ-019 avm_clken  output  1  constant 1.
REQ-020 avm_readdata  input  DATA_W  read data, valid RD_LAT cycles after the read address is presented.

Function
REQ-021 States: IDLE, WRITE, READ, DRAIN, DONE.
REQ-022 IDLE/DONE: start=1 latches base_addr, word_count, seed; clears err_count, first_err_addr, done; enters WRITE, or DONE with pass=1 in the next cycle if word_count=0.
REQ-023 start while busy is ignored; inputs are not re-sampled mid-run.
REQ-024 Pattern for index i: data(i) = seed + i, modulo 2^DATA_W.
REQ-025 Address for index i: (base_addr + i) modulo 2^ADDR_W; wrap past the top is legal.
REQ-026 WRITE: one write per cycle, index 0..N-1, avm_chipselect=avm_write=1; the first write appears in the cycle after start is sampled.
REQ-027 READ: directly follows WRITE; one read per cycle (chipselect=1, write=0), index 0..N-1.
REQ-028 DRAIN: RD_LAT cycles with chipselect=0 to collect outstanding read data.
REQ-029 Compare: readdata at cycle t is checked against data(index issued at t-RD_LAT) via an RD_LAT-deep index/address pipeline.
REQ-030 Mismatch: err_count increments by 1; first_err_addr records the address only on the first mismatch.
REQ-031 After DRAIN, enter DONE: done=1, pass=(err_count==0), busy=0.
REQ-032 Total run length is 2N+RD_LAT cycles from the first write to done asserting.
REQ-033 Outside WRITE/READ, avm_chipselect=avm_write=0 and avm_address holds its last value.

Reset
REQ-034 reset_n=0 at a clock edge forces IDLE; busy, done, pass, chipselect, write, err_count, first_err_addr, avm_address and avm_writedata reset to 0.
REQ-035 Reset mid-run aborts immediately: no further transfers, and no done or pass is reported for the aborted run.

Structure
REQ-036 Package onchip_mem_tester_pkg holds the state enum and default width constants.
REQ-037 Sub-module mem_pattern_gen computes data(i) and address(i) from seed, base, and index; one instance serves writes and one serves the compare path.

Verification
REQ-038 base=0, N=16, seed=0xA5A50000, model memory -> 16 writes of 0xA5A50000..0xA5A5000F, 16 reads, done at cycle 33 (RD_LAT=1), pass=1, err_count=0.
REQ-039 base=0x1FFE, N=4 -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001 on both write and read, pass=1.
REQ-040 Model corrupts bit 0 at addresses 5 and 9, base=0, N=16 -> pass=0, err_count=2, first_err_addr=5.
REQ-041 N=0 -> no chipselect pulses; done=1, pass=1 one cycle after start.
REQ-042 start pulsed again during READ -> ignored, run completes unchanged; reset_n low during WRITE -> next cycle IDLE, chipselect=0, done=0.
REQ-043 RD_LAT=2, N=8192 -> full memory sweep, done at cycle 16386, pass=1.

Source files
------------

// File: rtl/onchip_mem_tester_pkg.sv
`default_nettype none
//==============================================================================
// Module      : onchip_mem_tester_pkg
// Description : Shared state encoding and default widths for the on-chip
//               memory tester.
// Revision    : 1.0 - initial release
//==============================================================================
package onchip_mem_tester_pkg;

   localparam int c_ADDR_W_DEF = 13;
   localparam int c_DATA_W_DEF = 32;
   localparam int c_RD_LAT_DEF = 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/onchip_mem_tester_if.sv
`default_nettype none
//==============================================================================
// Module      : onchip_mem_tester_if
// Description : Avalon-MM style bus between the tester (master) and the
//               on-chip memory under test (slave).
// Revision    : 1.0 - initial release
//==============================================================================
interface onchip_mem_tester_if
   import onchip_mem_tester_pkg::*;
#(
   parameter int ADDR_W = c_ADDR_W_DEF,
   parameter int DATA_W = c_DATA_W_DEF
) ();

   logic [ADDR_W-1:0]   address;
   logic                chipselect;
   logic                write;
   logic [DATA_W/8-1:0] byteenable;
   logic [DATA_W-1:0]   writedata;
   logic                clken;
   logic [DATA_W-1:0]   readdata;

   modport master (
      output address, chipselect, write, byteenable, writedata, clken,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write, byteenable, writedata, clken,
      output readdata
   );

endinterface
`default_nettype wire

// File: rtl/onchip_mem_tester_mem_pattern_gen.sv
`default_nettype none
//==============================================================================
// Module      : mem_pattern_gen
// Description : Test pattern for one index: address = base + index (wrapping
//               at the top of memory), data = seed + index.
// Revision    : 1.0 - initial release
//==============================================================================
module mem_pattern_gen
   import onchip_mem_tester_pkg::*;
#(
   parameter int ADDR_W = c_ADDR_W_DEF,
   parameter int DATA_W = c_DATA_W_DEF
) (
   input  logic [ADDR_W-1:0] base,
   input  logic [DATA_W-1:0] seed,
   input  logic [ADDR_W:0]   index,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   // Index never exceeds 2^ADDR_W-1, so its low bits are the full offset
   assign addr = base + index[ADDR_W-1:0];
   assign data = seed + DATA_W'(index);

endmodule
`default_nettype wire

// File: rtl/onchip_mem_tester.sv
`default_nettype none
//==============================================================================
// Module      : onchip_mem_tester
// Description : Writes an incrementing pattern over a window of on-chip
//               memory, reads it back and counts mismatches.
// Revision    : 1.0 - initial release
//==============================================================================
module onchip_mem_tester
   import onchip_mem_tester_pkg::*;
#(
   parameter int ADDR_W = c_ADDR_W_DEF,
   parameter int DATA_W = c_DATA_W_DEF,
   parameter int RD_LAT = c_RD_LAT_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [ADDR_W:0]      word_count,
   input  logic [DATA_W-1:0]    seed,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ADDR_W:0]      err_count,
   output logic [ADDR_W-1:0]    first_err_addr,
   onchip_mem_tester_if.master  avm
);

   localparam logic [ADDR_W:0] c_IDX_ONE    = (ADDR_W+1)'(1);
   localparam logic [1:0]      c_DRAIN_LAST = 2'(RD_LAT - 1);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W:0]     r_count;
   logic [DATA_W-1:0]   r_seed;
   logic [ADDR_W:0]     r_idx;
   logic [1:0]          r_drain;
   logic                r_busy;
   logic                r_done;
   logic                r_pass;
   logic [ADDR_W:0]     r_err_count;
   logic [ADDR_W-1:0]   r_first_err_addr;
   logic [ADDR_W-1:0]   r_address;
   logic [DATA_W-1:0]   r_writedata;
   logic                r_cs;
   logic                r_wr;
   logic [RD_LAT-1:0]   r_pipe_vld;
   logic [ADDR_W:0]     r_pipe_idx [RD_LAT];

   logic                w_last;
   logic [ADDR_W:0]     w_next_idx;
   logic [ADDR_W-1:0]   w_gen_addr;
   logic [DATA_W-1:0]   w_gen_data;
   logic [ADDR_W-1:0]   w_exp_addr;
   logic [DATA_W-1:0]   w_exp_data;
   logic                w_mismatch;
   logic [ADDR_W:0]     w_err_next;

   // r_idx is the index currently on the bus; the generator looks one ahead
   assign w_last     = ((r_idx + c_IDX_ONE) == r_count);
   assign w_next_idx = w_last ? '0 : (r_idx + c_IDX_ONE);

   mem_pattern_gen #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_gen_issue (
      .base   (r_base),
      .seed   (r_seed),
      .index  (w_next_idx),
      .addr   (w_gen_addr),
      .data   (w_gen_data)
   );

   mem_pattern_gen #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_gen_check (
      .base   (r_base),
      .seed   (r_seed),
      .index  (r_pipe_idx[RD_LAT-1]),
      .addr   (w_exp_addr),
      .data   (w_exp_data)
   );

   assign w_mismatch = r_pipe_vld[RD_LAT-1] && (avm.readdata != w_exp_data);
   assign w_err_next = r_err_count + (w_mismatch ? c_IDX_ONE : '0);

   // Run sequencer, read-return pipeline and mismatch bookkeeping
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state          <= ST_IDLE;
         r_base           <= '0;
         r_count          <= '0;
         r_seed           <= '0;
         r_idx            <= '0;
         r_drain          <= '0;
         r_busy           <= 1'b0;
         r_done           <= 1'b0;
         r_pass           <= 1'b0;
         r_err_count      <= '0;
         r_first_err_addr <= '0;
         r_address        <= '0;
         r_writedata      <= '0;
         r_cs             <= 1'b0;
         r_wr             <= 1'b0;
         r_pipe_vld       <= '0;
         for (int k = 0; k < RD_LAT; k++) begin
            r_pipe_idx[k] <= '0;
         end
      end else begin
         // Stage 0 captures the read on the bus this cycle; the last stage
         // lines up with the data returning now
         r_pipe_vld[0] <= (r_state == ST_READ);
         r_pipe_idx[0] <= r_idx;
         for (int k = 1; k < RD_LAT; k++) begin
            r_pipe_vld[k] <= r_pipe_vld[k-1];
            r_pipe_idx[k] <= r_pipe_idx[k-1];
         end

         if (w_mismatch) begin
            r_err_count <= w_err_next;
            if (r_err_count == '0) begin
               r_first_err_addr <= w_exp_addr;
            end
         end

         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_base           <= base_addr;
                  r_count          <= word_count;
                  r_seed           <= seed;
                  r_idx            <= '0;
                  r_err_count      <= '0;
                  r_first_err_addr <= '0;
                  if (word_count == '0) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_pass  <= 1'b1;
                  end else begin
                     // Index 0 comes straight from the inputs being latched
                     r_state     <= ST_WRITE;
                     r_busy      <= 1'b1;
                     r_done      <= 1'b0;
                     r_pass      <= 1'b0;
                     r_cs        <= 1'b1;
                     r_wr        <= 1'b1;
                     r_address   <= base_addr;
                     r_writedata <= seed;
                  end
               end
            end

            ST_WRITE: begin
               r_idx     <= w_next_idx;
               r_address <= w_gen_addr;
               if (w_last) begin
                  r_state <= ST_READ;
                  r_wr    <= 1'b0;
               end else begin
                  r_writedata <= w_gen_data;
               end
            end

            ST_READ: begin
               if (w_last) begin
                  r_state <= ST_DRAIN;
                  r_cs    <= 1'b0;
                  r_drain <= '0;
               end else begin
                  r_idx     <= w_next_idx;
                  r_address <= w_gen_addr;
               end
            end

            ST_DRAIN: begin
               if (r_drain == c_DRAIN_LAST) begin
                  // The final compare lands on this same edge
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_next == '0);
               end else begin
                  r_drain <= r_drain + 2'd1;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_cs    <= 1'b0;
               r_wr    <= 1'b0;
            end
         endcase
      end
   end

   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign err_count      = r_err_count;
   assign first_err_addr = r_first_err_addr;

   assign avm.address    = r_address;
   assign avm.chipselect = r_cs;
   assign avm.write      = r_wr;
   assign avm.byteenable = '1;
   assign avm.writedata  = r_writedata;
   assign avm.clken      = 1'b1;

endmodule
`default_nettype wire
